// File: rtl/pipe_chk_pkg.sv
// pipe_chk_pkg: shared constants, FIFO entry layout and parity helper for the
// ALU result checker slice.
package pipe_chk_pkg;

   localparam int unsigned DW_DEF    = 5;  // {carry, res[3:0]}
   localparam int unsigned DEPTH_DEF = 4;

   // One stored FIFO entry: the parity-error flag above the result word.
   typedef struct packed {
      logic              err;
      logic [DW_DEF-1:0] data;
   } fifo_entry_t;

   // True when par is the correct even-parity bit for data.
   // Callers zero-extend narrower words; zero padding does not change parity.
   function automatic logic even_parity_ok(input logic [31:0] data, input logic par);
      return ~(^data ^ par);
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO.
//   clk_i      clock
//   rst_ni     asynchronous active-low clear (pointers and storage)
//   wr_en_i    write request; ignored when full unless a read happens too
//   wr_data_i  write word
//   rd_en_i    read request; ignored when empty
//   rd_data_o  head entry, valid whenever empty_o is low
//   full_o     DEPTH entries held
//   empty_o    no entries held
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_ok, rd_ok;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   assign rd_ok = rd_en_i & ~empty_o;
   // A write into a full FIFO is fine when the head is consumed on the same edge.
   assign wr_ok = wr_en_i & (~full_o | rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is cleared too, so the head reads as zero straight after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '{default: '0};
      end else if (wr_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

endmodule

// File: rtl/pipe_result_checker.sv
// pipe_result_checker: receive end of the ALU result interface.
// Captures one {carry,res} word per cycle, checks its even parity, queues the
// word with its error flag in a FWFT FIFO and offers it downstream via
// valid/ready. The upstream cannot stall: words arriving at a full FIFO are
// dropped and flagged as overflow.
//   clk        clock
//   clear_neg  asynchronous active-low reset
//   in_valid / in_data / in_parity   upstream word (no backpressure)
//   out_valid / out_ready / out_data / out_err   downstream handshake, head entry
//   fifo_full  FIFO holds DEPTH words
//   err_count  saturating parity-error count
//   err_sticky sticky parity-error flag
//   overflow   sticky dropped-word flag
//   clr_err    synchronous clear of err_count, err_sticky, overflow
module pipe_result_checker
   import pipe_chk_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned CW    = 8
) (
   input  logic          clk,
   input  logic          clear_neg,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_parity,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_err,
   output logic          fifo_full,
   output logic [CW-1:0] err_count,
   output logic          err_sticky,
   output logic          overflow,
   input  logic          clr_err
);

   logic          s_valid_q;
   logic [DW-1:0] s_data_q;
   logic          s_par_q;

   logic          perr;
   logic          fifo_empty;
   logic [DW:0]   head;
   logic          rd_fire, wr_fire, drop, err_evt;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sticky_q, sticky_d;
   logic          ovf_q, ovf_d;

   // Capture stage: unconditionally registers the interface every edge.
   always_ff @(posedge clk or negedge clear_neg) begin
      if (!clear_neg) begin
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_par_q   <= 1'b0;
      end else begin
         s_valid_q <= in_valid;
         s_data_q  <= in_data;
         s_par_q   <= in_parity;
      end
   end

   assign perr = ~even_parity_ok(32'(s_data_q), s_par_q);

   assign out_valid = ~fifo_empty;
   assign rd_fire   = out_valid & out_ready;
   assign wr_fire   = s_valid_q & (~fifo_full | rd_fire);
   assign drop      = s_valid_q & ~wr_fire;
   // Dropped words are still parity-checked.
   assign err_evt   = s_valid_q & perr;

   sync_fifo_fwft #(
      .WIDTH (DW + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clk),
      .rst_ni    (clear_neg),
      .wr_en_i   (wr_fire),
      .wr_data_i ({perr, s_data_q}),
      .rd_en_i   (out_ready),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign out_err  = head[DW];
   assign out_data = head[DW-1:0];

   // Clear is applied first so a same-cycle error event overrides it.
   always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      ovf_d    = ovf_q;
      if (clr_err) begin
         cnt_d    = '0;
         sticky_d = 1'b0;
         ovf_d    = 1'b0;
      end
      if (err_evt) begin
         sticky_d = 1'b1;
         if (cnt_d != '1) cnt_d = cnt_d + CW'(1);
      end
      if (drop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge clear_neg) begin
      if (!clear_neg) begin
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         ovf_q    <= ovf_d;
      end
   end

   assign err_count  = cnt_q;
   assign err_sticky = sticky_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_pipe_result_checker.sv
module tb_pipe_result_checker;

   logic       clk;
   logic       clear_neg;
   logic       in_valid;
   logic [4:0] in_data;
   logic       in_parity;
   logic       out_ready;
   logic       clr_err;

   logic       out_valid, out_err, fifo_full, err_sticky, overflow;
   logic [4:0] out_data;
   logic [7:0] err_count;

   logic       o2_valid, o2_err, o2_full, o2_sticky, o2_ovf;
   logic [4:0] o2_data;
   logic [1:0] o2_count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   pipe_result_checker dut (
      .clk        (clk),
      .clear_neg  (clear_neg),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_parity  (in_parity),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_err    (out_err),
      .fifo_full  (fifo_full),
      .err_count  (err_count),
      .err_sticky (err_sticky),
      .overflow   (overflow),
      .clr_err    (clr_err)
   );

   // Narrow-counter instance for saturation; shares all stimulus.
   pipe_result_checker #(.CW(2)) dut2 (
      .clk        (clk),
      .clear_neg  (clear_neg),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_parity  (in_parity),
      .out_valid  (o2_valid),
      .out_ready  (out_ready),
      .out_data   (o2_data),
      .out_err    (o2_err),
      .fifo_full  (o2_full),
      .err_count  (o2_count),
      .err_sticky (o2_sticky),
      .overflow   (o2_ovf),
      .clr_err    (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] d, input logic bad);
      in_valid  = v;
      in_data   = d;
      in_parity = (^d) ^ bad;
   endtask

   task automatic test_reset();
      clear_neg = 1'b0; in_valid = 1'b0; in_data = '0; in_parity = 1'b0;
      out_ready = 1'b0; clr_err = 1'b0;
      #2;
      n_checks++;
      if ({out_valid, out_data, out_err, fifo_full, err_count, err_sticky, overflow} !== 18'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b d=%b e=%b f=%b c=%0d s=%b o=%b, want all 0",
                  out_valid, out_data, out_err, fifo_full, err_count, err_sticky, overflow);
      end
      n_checks++;
      if (o2_count !== 2'd0) begin
         n_fail++; $display("FAIL reset_cnt2: got %0d want 0", o2_count);
      end
      #10 clear_neg = 1'b1;
      tick();
   endtask

   task automatic test_clean();
      // Invalid words with wrong parity must be ignored.
      drive(1'b0, 5'b01110, 1'b1);
      tick(); tick();
      n_checks++;
      if (err_count !== 8'd0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL invalid_ignored: cnt=%0d v=%b want 0 0", err_count, out_valid);
      end
      drive(1'b1, 5'b10011, 1'b0);
      n_checks++;
      if (in_parity !== 1'b1) begin
         n_fail++; $display("FAIL clean_parity_bit: got %b want 1", in_parity);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL clean_latency1: out_valid=%b want 0", out_valid);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 5'b10011 || out_err !== 1'b0 || err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL clean_word: v=%b d=%b e=%b c=%0d want 1 10011 0 0", out_valid, out_data, out_err, err_count);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL clean_pop: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_bad_parity();
      in_valid = 1'b1; in_data = 5'b00101; in_parity = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 5'b00101 || out_err !== 1'b1 ||
          err_count !== 8'd1 || err_sticky !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_parity: v=%b d=%b e=%b c=%0d s=%b want 1 00101 1 1 1",
                  out_valid, out_data, out_err, err_count, err_sticky);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      n_checks++;
      if (err_count !== 8'd0 || err_sticky !== 1'b0) begin
         n_fail++; $display("FAIL clr_err: c=%0d s=%b want 0 0", err_count, err_sticky);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 5'b00101 || out_err !== 1'b1) begin
         n_fail++; $display("FAIL clr_keeps_entry: v=%b d=%b e=%b want 1 00101 1", out_valid, out_data, out_err);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 5'(k), 1'b0);
         tick();
      end
      in_valid = 1'b0;
      // Words 1..4 written; word 5 still in the capture stage.
      n_checks++;
      if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL ovf_full4: full=%b ovf=%b want 1 0", fifo_full, overflow);
      end
      tick();
      n_checks++;
      if (overflow !== 1'b1 || fifo_full !== 1'b1) begin
         n_fail++; $display("FAIL ovf_drop5: ovf=%b full=%b want 1 1", overflow, fifo_full);
      end
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 5'(k)) begin
            n_fail++; $display("FAIL ovf_drain%0d: v=%b d=%0d want 1 %0d", k, out_valid, out_data, k);
         end
         tick();
      end
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || fifo_full !== 1'b0 || err_count !== 8'd0) begin
         n_fail++; $display("FAIL ovf_empty: v=%b full=%b c=%0d want 0 0 0", out_valid, fifo_full, err_count);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear: ovf=%b want 0", overflow);
      end
   endtask

   task automatic test_full_rw();
      out_ready = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 5'(5 + k), 1'b0);
         tick();
         if (k >= 5) begin
            n_checks++;
            if (fifo_full !== 1'b1 || out_data !== 5'(k + 1) || overflow !== 1'b0) begin
               n_fail++;
               $display("FAIL full_rw%0d: full=%b d=%0d ovf=%b want 1 %0d 0", k, fifo_full, out_data, overflow, k + 1);
            end
            out_ready = 1'b1;
         end
      end
      in_valid = 1'b0;
      tick();
      for (int w = 10; w <= 13; w++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 5'(w) || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_rw_drain%0d: v=%b d=%0d ovf=%b want 1 %0d 0", w, out_valid, out_data, overflow, w);
         end
         tick();
      end
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL full_rw_empty: v=%b want 0", out_valid);
      end
   endtask

   task automatic test_saturation();
      out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 5'(k), 1'b1);
         tick();
      end
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (o2_count !== 2'd3 || o2_sticky !== 1'b1) begin
         n_fail++; $display("FAIL sat_cw2: c=%0d s=%b want 3 1", o2_count, o2_sticky);
      end
      n_checks++;
      if (err_count !== 8'd5) begin
         n_fail++; $display("FAIL sat_cw8: c=%0d want 5", err_count);
      end
      drive(1'b1, 5'd9, 1'b1);
      tick();
      in_valid = 1'b0;
      clr_err  = 1'b1;
      tick();
      clr_err  = 1'b0;
      n_checks++;
      if (o2_count !== 2'd1 || err_count !== 8'd1 || err_sticky !== 1'b1) begin
         n_fail++; $display("FAIL clr_vs_err: c2=%0d c=%0d s=%b want 1 1 1", o2_count, err_count, err_sticky);
      end
      tick(); tick();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL sat_drain: v=%b want 0", out_valid);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(1'b1, 5'd1, 1'b0); tick();
      drive(1'b1, 5'd2, 1'b1); tick();
      drive(1'b1, 5'd3, 1'b0); tick();
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 5'd1 || err_count !== 8'd2 || err_sticky !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset: v=%b d=%0d c=%0d s=%b want 1 1 2 1", out_valid, out_data, err_count, err_sticky);
      end
      #1 clear_neg = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_data, out_err, fifo_full, err_count, err_sticky, overflow} !== 18'd0) begin
         n_fail++;
         $display("FAIL async_reset: v=%b d=%b e=%b f=%b c=%0d s=%b o=%b want all 0",
                  out_valid, out_data, out_err, fifo_full, err_count, err_sticky, overflow);
      end
      #1 clear_neg = 1'b1;
      drive(1'b1, 5'h1A, 1'b0);
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_lat1: v=%b want 0", out_valid);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 5'h1A || out_err !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_word: v=%b d=%h e=%b want 1 1a 0", out_valid, out_data, out_err);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_only_one: v=%b want 0", out_valid);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_bad_parity();
      test_overflow();
      test_full_rw();
      test_saturation();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
